// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite timer slave: response codes, channel FSM states
// and the address decode helper used by both the write and read paths.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_EXEC = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_EXEC = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

    // The word index is addr[31:2]; a request is legal only when it is word aligned
    // and that index falls inside the implemented register file.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] num_regs);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] == 2'b00) && (word_idx < num_regs);
    endfunction

endpackage

// File: rtl/axil_wr_path.sv
// AXI4-Lite write path: independent AW/W latches, write FSM and B channel.
// With AXIL_WSTRB_EN defined any WSTRB is passed through; otherwise only full-word writes are legal.
module axil_wr_path
    import axi4lite_pkg::*;
#(
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int NUM_REGS = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [AW-1:0] AWADDR,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [DW-1:0] WDATA,
    input  logic [3:0]    WSTRB,
    input  logic          WVALID,
    output logic          WREADY,
    output logic [1:0]    BRESP,
    output logic          BVALID,
    input  logic          BREADY,
    output logic          wr_exec,
    output logic          wr_legal,
    output logic [AW-3:0] wr_idx,
    output logic [DW-1:0] wr_data,
    output logic [3:0]    wr_strb
);

    wr_state_t     state_r;
    logic          aw_full_r;
    logic          w_full_r;
    logic          awready_r;
    logic          wready_r;
    logic          bvalid_r;
    logic [1:0]    bresp_r;
    logic [AW-1:0] awaddr_r;
    logic [DW-1:0] wdata_r;
    logic [3:0]    wstrb_r;

    logic          aw_hs_s;
    logic          w_hs_s;
    logic          both_have_s;
    logic          legal_s;

    // Handshake detection and legality of the latched request.
    always_comb begin
        aw_hs_s     = AWVALID && awready_r;
        w_hs_s      = WVALID && wready_r;
        both_have_s = (aw_full_r || aw_hs_s) && (w_full_r || w_hs_s);
`ifdef AXIL_WSTRB_EN
        legal_s     = addr_legal({{(32-AW){1'b0}}, awaddr_r}, NUM_REGS);
`else
        legal_s     = addr_legal({{(32-AW){1'b0}}, awaddr_r}, NUM_REGS) && (wstrb_r == 4'hF);
`endif
    end

    // Write FSM: the ready flags drop on their own handshake and reopen only after the B handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r   <= W_IDLE;
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awaddr_r  <= {AW{1'b0}};
            wdata_r   <= {DW{1'b0}};
            wstrb_r   <= 4'h0;
        end else begin
            case (state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awaddr_r  <= AWADDR;
                        aw_full_r <= 1'b1;
                        awready_r <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wdata_r  <= WDATA;
                        wstrb_r  <= WSTRB;
                        w_full_r <= 1'b1;
                        wready_r <= 1'b0;
                    end
                    if (both_have_s) begin
                        state_r <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    bresp_r  <= legal_s ? RESP_OKAY : RESP_SLVERR;
                    bvalid_r <= 1'b1;
                    state_r  <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_r  <= 1'b0;
                        aw_full_r <= 1'b0;
                        w_full_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        state_r   <= W_IDLE;
                    end
                end
                default: begin
                    state_r <= W_IDLE;
                end
            endcase
        end
    end

    assign AWREADY  = awready_r;
    assign WREADY   = wready_r;
    assign BVALID   = bvalid_r;
    assign BRESP    = bresp_r;
    assign wr_exec  = (state_r == W_EXEC);
    assign wr_legal = legal_s;
    assign wr_idx   = awaddr_r[AW-1:2];
    assign wr_data  = wdata_r;
`ifdef AXIL_WSTRB_EN
    assign wr_strb  = wstrb_r;
`else
    assign wr_strb  = 4'hF;
`endif

endmodule

// File: rtl/axi4lite_slave_ctrl.sv
// AXI4-Lite slave controller for the timer register file: read FSM, write-priority arbitration
// and the register-port mux. AXIL_WSTRB_EN enables partial-word writes in the write path.
module axi4lite_slave_ctrl
    import axi4lite_pkg::*;
#(
    parameter int AW       = 4,
    parameter int DW       = 32,
    parameter int NUM_REGS = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [AW-1:0] AWADDR,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [DW-1:0] WDATA,
    input  logic [3:0]    WSTRB,
    input  logic          WVALID,
    output logic          WREADY,
    output logic [1:0]    BRESP,
    output logic          BVALID,
    input  logic          BREADY,
    input  logic [AW-1:0] ARADDR,
    input  logic          ARVALID,
    output logic          ARREADY,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    RRESP,
    output logic          RVALID,
    input  logic          RREADY,
    output logic          reg_wr_en,
    output logic          reg_rd_en,
    output logic [AW-3:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic [3:0]    reg_wstrb,
    input  logic [DW-1:0] reg_rdata
);

    logic          wr_exec_s;
    logic          wr_legal_s;
    logic [AW-3:0] wr_idx_s;
    logic [DW-1:0] wr_data_s;
    logic [3:0]    wr_strb_s;

    rd_state_t     rd_state_r;
    logic [AW-1:0] araddr_r;
    logic          arready_r;
    logic          rvalid_r;
    logic [DW-1:0] rdata_r;
    logic [1:0]    rresp_r;
    logic          rd_legal_s;
    logic          rd_grant_s;

    axil_wr_path #(
        .AW       (AW),
        .DW       (DW),
        .NUM_REGS (NUM_REGS)
    ) u_wr_path (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .wr_exec  (wr_exec_s),
        .wr_legal (wr_legal_s),
        .wr_idx   (wr_idx_s),
        .wr_data  (wr_data_s),
        .wr_strb  (wr_strb_s)
    );

    // An executing write owns the register port, illegal or not; the read retries next cycle.
    always_comb begin
        rd_legal_s = addr_legal({{(32-AW){1'b0}}, araddr_r}, NUM_REGS);
        rd_grant_s = (rd_state_r == R_EXEC) && !wr_exec_s;
        reg_wr_en  = wr_exec_s && wr_legal_s;
        reg_rd_en  = rd_grant_s && rd_legal_s;
        if (wr_exec_s) begin
            reg_addr  = wr_idx_s;
            reg_wdata = wr_data_s;
            reg_wstrb = wr_strb_s;
        end else if (rd_grant_s) begin
            reg_addr  = araddr_r[AW-1:2];
            reg_wdata = {DW{1'b0}};
            reg_wstrb = 4'h0;
        end else begin
            reg_addr  = {(AW-2){1'b0}};
            reg_wdata = {DW{1'b0}};
            reg_wstrb = 4'h0;
        end
    end

    // Read FSM: capture reg_rdata in the granted cycle and hold the R beat until RREADY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state_r <= R_IDLE;
            araddr_r   <= {AW{1'b0}};
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= {DW{1'b0}};
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ARVALID && arready_r) begin
                        araddr_r   <= ARADDR;
                        arready_r  <= 1'b0;
                        rd_state_r <= R_EXEC;
                    end
                end
                R_EXEC: begin
                    if (rd_grant_s) begin
                        rdata_r    <= rd_legal_s ? reg_rdata : {DW{1'b0}};
                        rresp_r    <= rd_legal_s ? RESP_OKAY : RESP_SLVERR;
                        rvalid_r   <= 1'b1;
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = rresp_r;

endmodule

// File: tb/tb_axi4lite_slave_ctrl.sv
// Scoreboard bench for axi4lite_slave_ctrl: directed protocol cases plus randomized traffic
// checked against a word-array reference model of the timer register file.
`timescale 1ns/1ps
module tb_axi4lite_slave_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NREGS = 3;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [AW-1:0] AWADDR = 4'h0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [DW-1:0] WDATA = 32'h0;
    logic [3:0]    WSTRB = 4'h0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [AW-1:0] ARADDR = 4'h0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-3:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [3:0]    reg_wstrb;
    logic [DW-1:0] reg_rdata;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  b_q[$];
    rexp_t       r_q[$];
    logic [31:0] dut_mem [4] = '{default: 32'h0};
    logic [31:0] ref_mem [4];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_cyc = 0;
    int rd_cyc = 0;
    logic [1:0]  wr_addr_seen;
    logic [1:0]  rd_addr_seen;
    logic [31:0] wr_data_seen;
    logic [3:0]  wr_strb_seen;

    axi4lite_slave_ctrl #(.AW(AW), .DW(DW), .NUM_REGS(NREGS)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Timer register file seen by the DUT.
    always @(posedge ACLK) begin
        if (reg_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (reg_wstrb[b]) dut_mem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
            end
        end
    end
    assign reg_rdata = dut_mem[reg_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit rd_legal(input logic [3:0] a);
        int unsigned addr;
        addr = a;
        return (addr % 4 == 0) && (addr / 4 < NREGS);
    endfunction

    function automatic bit wr_legal(input logic [3:0] a, input logic [3:0] s);
        bit ok;
        ok = rd_legal(a);
`ifndef AXIL_WSTRB_EN
        if (s != 4'hF) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [3:0] s);
`ifdef AXIL_WSTRB_EN
        return s;
`else
        return (s == 4'hF) ? 4'hF : 4'hF;
`endif
    endfunction

    task automatic ref_store(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // Monitor: strobe bookkeeping and scoreboard pops on every B/R handshake.
    always @(negedge ACLK) begin
        logic [1:0] be;
        rexp_t      re;
        if (reg_wr_en || reg_rd_en) chk("strobe_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
        if (reg_wr_en) begin
            wr_cnt++; wr_cyc = cyc; wr_addr_seen = reg_addr;
            wr_data_seen = reg_wdata; wr_strb_seen = reg_wstrb;
        end
        if (reg_rd_en) begin
            rd_cnt++; rd_cyc = cyc; rd_addr_seen = reg_addr;
        end
        if (BVALID && BREADY) begin
            chk("b_expected", 32'(b_q.size() != 0), 32'd1);
            if (b_q.size() != 0) begin
                be = b_q.pop_front();
                chk("bresp", 32'(BRESP), 32'(be));
            end
        end
        if (RVALID && RREADY) begin
            chk("r_expected", 32'(r_q.size() != 0), 32'd1);
            if (r_q.size() != 0) begin
                re = r_q.pop_front();
                chk("rresp", 32'(RRESP), 32'(re.resp));
                chk("rdata", RDATA, re.data);
            end
        end
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, input int strb_lat);
        bit ok, aw_done, w_done, seen;
        int c, k, n0;
        logic [1:0] resp;
        ok = wr_legal(a, s);
        resp = ok ? 2'b00 : 2'b10;
        b_q.push_back(resp);
        if (ok) ref_store(int'(a[3:2]), d, s);
        n0 = wr_cnt;
        aw_done = 1'b0; w_done = 1'b0; c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            AWVALID = !aw_done && (c >= aw_dly); AWADDR = a;
            WVALID  = !w_done && (c >= w_dly);   WDATA = d; WSTRB = s;
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_done = 1'b1;
            if (WVALID && WREADY) w_done = 1'b1;
            @(posedge ACLK); #1;
            c++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
        k = cyc;
        seen = 1'b0; c = 0;
        while (!seen && c < 20) begin
            @(negedge ACLK); seen = BVALID; c++;
        end
        chk("b_latency", cyc - k, 32'd1);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            chk("bvalid_hold", 32'(BVALID), 32'd1);
            chk("bresp_hold", 32'(BRESP), 32'(resp));
        end
        @(posedge ACLK); #1 BREADY = 1'b1;
        @(posedge ACLK); #1 BREADY = 1'b0;
        chk("wr_strobe_count", wr_cnt - n0, ok ? 1 : 0);
        if (ok) begin
            chk("wr_strobe_cycle", wr_cyc - k, strb_lat);
            chk("reg_addr_wr", 32'(wr_addr_seen), 32'(a[3:2]));
            chk("reg_wdata", wr_data_seen, d);
            chk("reg_wstrb", 32'(wr_strb_seen), 32'(exp_strb(s)));
        end
    endtask

    task automatic axi_read(input logic [3:0] a, input int ar_dly, input int r_dly, input int extra);
        bit ok, done, seen;
        int c, k, n0;
        rexp_t e;
        ok = rd_legal(a);
        e.data = ok ? ref_mem[a[3:2]] : 32'h0;
        e.resp = ok ? 2'b00 : 2'b10;
        r_q.push_back(e);
        n0 = rd_cnt;
        done = 1'b0; c = 0;
        while (!done && c < 50) begin
            ARVALID = (c >= ar_dly); ARADDR = a;
            @(negedge ACLK);
            if (ARVALID && ARREADY) done = 1'b1;
            @(posedge ACLK); #1;
            c++;
        end
        ARVALID = 1'b0;
        chk("ar_handshake", 32'(done), 32'd1);
        k = cyc;
        seen = 1'b0; c = 0;
        while (!seen && c < 20) begin
            @(negedge ACLK); seen = RVALID; c++;
        end
        chk("r_latency", cyc - k, 1 + extra);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            chk("rvalid_hold", 32'(RVALID), 32'd1);
            chk("rdata_hold", RDATA, e.data);
        end
        @(posedge ACLK); #1 RREADY = 1'b1;
        @(posedge ACLK); #1 RREADY = 1'b0;
        chk("rd_strobe_count", rd_cnt - n0, ok ? 1 : 0);
        if (ok) begin
            chk("rd_strobe_cycle", rd_cyc - k, extra);
            chk("reg_addr_rd", 32'(rd_addr_seen), 32'(a[3:2]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        logic [3:0] ra, rs;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        chk("reset_readys", 32'({AWREADY, WREADY, ARREADY}), 32'h7);
        chk("reset_valids", 32'({BVALID, RVALID}), 32'h0);
        chk("reset_resps", 32'({BRESP, RRESP}), 32'h0);
        chk("reset_rdata", RDATA, 32'h0);
        chk("reset_strobes", 32'({reg_wr_en, reg_rd_en, reg_addr, reg_wstrb}), 32'h0);
        chk("reset_reg_wdata", reg_wdata, 32'h0);
        @(posedge ACLK); #1;

        axi_write(4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        axi_write(4'h0, 32'hCAFE0001, 4'hF, 3, 0, 5, 0);
        axi_write(4'h8, 32'h12345678, 4'hF, 0, 1, 0, 0);
        axi_read(4'h8, 0, 2, 0);
        axi_read(4'h2, 0, 0, 0);
        axi_write(4'hC, 32'h11112222, 4'hF, 0, 0, 0, 0);
        fork
            axi_write(4'h4, 32'h0BADF00D, 4'hF, 0, 0, 1, 0);
            axi_read(4'h8, 0, 0, 1);
        join
        axi_write(4'h0, 32'h55AA55AA, 4'h3, 1, 0, 0, 0);
        axi_read(4'h0, 0, 0, 0);
        axi_read(4'h4, 1, 0, 0);

        repeat (150) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                rs = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
                axi_write(ra, $urandom, rs, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 0);
            end else begin
                axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            end
        end

        @(posedge ACLK); #1 ARADDR = 4'h4; ARVALID = 1'b1;
        @(posedge ACLK); #1 ARVALID = 1'b0;
        c = 0;
        while (!RVALID && c < 20) begin
            @(negedge ACLK); c++;
        end
        chk("rvalid_before_reset", 32'(RVALID), 32'd1);
        #2 ARESETn = 1'b0;
        #1;
        chk("rvalid_in_reset", 32'(RVALID), 32'd0);
        chk("arready_in_reset", 32'(ARREADY), 32'd1);
        @(posedge ACLK); #1 ARESETn = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            chk("rvalid_after_reset", 32'(RVALID), 32'd0);
            chk("arready_after_reset", 32'(ARREADY), 32'd1);
        end

        chk("b_queue_drained", b_q.size(), 32'd0);
        chk("r_queue_drained", r_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
